// File: rtl/dna_sched_pkg.sv
// dna_sched_pkg: shared types and constants for the DNA search scheduler
package dna_sched_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        REPORT
    } state_t;

    // One-hot requester select: bit 0 = requester 0, bit 1 = requester 1
    typedef logic [1:0] grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter producing a one-hot grant
import dna_sched_pkg::*;

module rr_arbiter2 (
    input  grant_t req,
    input  grant_t last_grant,
    output grant_t grant
);

    // On contention the requester not served last wins; otherwise the sole requester
    always_comb begin
        grant = (req == 2'b11) ? ~last_grant :
                req[0]         ? 2'b01 :
                req[1]         ? 2'b10 : 2'b00;
    end

endmodule

// File: rtl/dna_search_sched.sv
// dna_search_sched: round-robin job scheduler for a pattern searcher; DNA_SCHED_TIMEOUT_EN adds a WAIT watchdog
import dna_sched_pkg::*;

module dna_search_sched #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       ack,
    output logic             res_found,
    output logic             res_error,
    output logic             res_timeout,
    output logic             ready,
    output logic [LEN_W-1:0] dna_length,
    input  logic             done,
    input  logic             found_it,
    input  logic             error,
    output logic             busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    grant_t           grant_q, grant_d;
    grant_t           last_q, last_d;
    grant_t           arb_grant;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] sel_len;
    logic             found_q, found_d;
    logic             error_q, error_d;

`ifdef DNA_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    rr_arbiter2 u_arb (
        .req        (req),
        .last_grant (last_q),
        .grant      (arb_grant)
    );

    assign sel_len = arb_grant[0] ? len0 : len1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        len_d   = len_q;
        found_d = found_q;
        error_d = error_q;
`ifdef DNA_SCHED_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_d = arb_grant;
                    last_d  = arb_grant;
                    len_d   = sel_len;
                    found_d = 1'b0;
                    // A zero-length job never reaches the searcher and reports as an error
                    error_d = (sel_len == '0);
                    state_d = (sel_len == '0) ? REPORT : ISSUE;
`ifdef DNA_SCHED_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef DNA_SCHED_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            WAIT: begin
                if (done) begin
                    found_d = found_it;
                    error_d = error;
                    state_d = REPORT;
                end
`ifdef DNA_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    found_d   = 1'b0;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 2'b10;
            len_q   <= '0;
            found_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            len_q   <= len_d;
            found_q <= found_d;
            error_q <= error_d;
        end
    end

`ifdef DNA_SCHED_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign res_timeout = (state_q == REPORT) & timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

    assign ready      = (state_q == ISSUE);
    assign ack        = (state_q == REPORT) ? grant_q : 2'b00;
    assign res_found  = (state_q == REPORT) & found_q;
    assign res_error  = (state_q == REPORT) & error_q;
    assign busy       = (state_q != IDLE);
    assign dna_length = len_q;

endmodule

// File: tb/tb_dna_search_sched.sv
// tb_dna_search_sched: directed self-checking bench for dna_search_sched
module tb_dna_search_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] len0 = '0;
    logic [15:0] len1 = '0;
    logic [1:0]  ack;
    logic        res_found, res_error, res_timeout, ready, busy;
    logic [15:0] dna_length;
    logic        done = 1'b0;
    logic        found_it = 1'b0;
    logic        error = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_ready = 0;
    int n_ack = 0;
    int snap_ready, snap_ack;

    dna_search_sched #(.TIMEOUT_CYCLES(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .len0        (len0),
        .len1        (len1),
        .ack         (ack),
        .res_found   (res_found),
        .res_error   (res_error),
        .res_timeout (res_timeout),
        .ready       (ready),
        .dna_length  (dna_length),
        .done        (done),
        .found_it    (found_it),
        .error       (error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ready) n_ready++;
        if (ack != 2'b00) n_ack++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        step(3);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_ready", ready, 0);
        check("rst_len", dna_length, 0);
        check("rst_res", {res_found, res_error, res_timeout}, 0);
        reset = 1'b0;
        step(1);

        // single job: len 45, done 10 cycles after ready, req dropped mid-job
        snap_ready = n_ready;
        len0 = 16'd45;
        req = 2'b01;
        step(1);
        check("j1_ready", ready, 1);
        check("j1_len", dna_length, 45);
        step(1);
        req = 2'b00;
        step(8);
        check("j1_wait_ack", ack, 0);
        done = 1'b1;
        found_it = 1'b1;
        step(1);
        check("j1_ack", ack, 2'b01);
        check("j1_res", {res_found, res_error, res_timeout}, 3'b100);
        done = 1'b0;
        found_it = 1'b0;
        step(1);
        check("j1_ack_off", ack, 0);
        check("j1_idle", busy, 0);
        check("j1_ready_cnt", n_ready - snap_ready, 1);

        // both request from reset: 0 first, then 1, then 0 again
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        len0 = 16'd10;
        len1 = 16'd20;
        req = 2'b11;
        step(1);
        check("rr_first_ready", ready, 1);
        check("rr_first_len", dna_length, 10);
        done = 1'b1;
        step(1);
        check("rr_done_in_issue", ack, 0);
        check("rr_wait_busy", busy, 1);
        step(1);
        check("rr_first_ack", ack, 2'b01);
        check("rr_first_res", {res_found, res_error}, 2'b00);
        done = 1'b0;
        step(1);
        check("rr_idle", busy, 0);
        step(1);
        check("rr_second_ready", ready, 1);
        check("rr_second_len", dna_length, 20);
        step(1);
        done = 1'b1;
        found_it = 1'b1;
        step(1);
        check("rr_second_ack", ack, 2'b10);
        check("rr_second_found", res_found, 1);
        done = 1'b0;
        found_it = 1'b0;
        step(1);
        snap_ack = n_ack;
        step(1);
        check("rr_third_len", dna_length, 10);
        check("rr_third_ready", ready, 1);
        step(1);

        // reset while in WAIT drops the job without an ack
        reset = 1'b1;
        req = 2'b00;
        step(1);
        check("rw_busy", busy, 0);
        check("rw_len", dna_length, 0);
        check("rw_ack", ack, 0);
        reset = 1'b0;
        step(3);
        check("rw_no_ack", n_ack - snap_ack, 0);

        // zero-length job on requester 1
        snap_ready = n_ready;
        len1 = 16'd0;
        req = 2'b10;
        step(1);
        check("z_ack", ack, 2'b10);
        check("z_res", {res_found, res_error, res_timeout}, 3'b010);
        req = 2'b00;
        step(1);
        check("z_idle", busy, 0);
        check("z_no_ready", n_ready - snap_ready, 0);

        // done while idle with nothing pending
        snap_ack = n_ack;
        done = 1'b1;
        found_it = 1'b1;
        step(3);
        check("di_busy", busy, 0);
        check("di_no_ack", n_ack - snap_ack, 0);
        done = 1'b0;
        found_it = 1'b0;
        step(1);

`ifdef DNA_SCHED_TIMEOUT_EN
        // searcher never answers: abort after 8 WAIT cycles
        len0 = 16'd5;
        req = 2'b01;
        step(1);
        check("to_ready", ready, 1);
        step(8);
        check("to_no_early_ack", ack, 0);
        step(1);
        check("to_ack", ack, 2'b01);
        check("to_res", {res_found, res_error, res_timeout}, 3'b011);
        req = 2'b00;
        step(1);
        check("to_idle", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
